// File: rtl/md_sched.sv
// md_sched -- multiply/divide scheduler for the E stage.
//
// Accepts mult/multu/div/divu/mthi/mtlo from E and owns the architectural
// HI/LO registers. Long operations compute their result at issue, hold it in
// hi_tmp/lo_tmp, and commit it after a fixed busy period timed by a
// down-counter. stall_md asks the hazard logic to freeze F/D while an md-class
// instruction sits in D behind a busy (or just-issuing) long operation.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears all state
//   start     E-stage md-class instruction valid this cycle
//   op[2:0]   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   A, B      forwarded rs / rt values
//   md_D      D-stage instruction is md-class
//   busy      long operation in progress
//   stall_md  freeze F/D and bubble E (combinational)
//   HI, LO    architectural HI / LO

module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_count, w_count_nx;
    logic            r_busy,  w_busy_nx;
    logic            r_div0,  w_div0_nx;
    logic [31:0]     r_hi, w_hi_nx;
    logic [31:0]     r_lo, w_lo_nx;
    logic [31:0]     r_hi_tmp, w_hi_tmp_nx;
    logic [31:0]     r_lo_tmp, w_lo_tmp_nx;

    // ---------------------------------------------------------------- arithmetic
    logic        w_is_long;
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_a_neg, w_b_neg, w_b_zero;
    logic [31:0] w_a_mag, w_b_mag, w_den_u, w_den_s;
    logic [31:0] w_qu, w_ru, w_qm, w_rm, w_qs, w_rs;

    assign w_is_long = (op[2] == 1'b0);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    assign w_a_neg  = A[31];
    assign w_b_neg  = B[31];
    assign w_b_zero = (B == '0);
    assign w_a_mag  = w_a_neg ? (~A + 32'd1) : A;
    assign w_b_mag  = w_b_neg ? (~B + 32'd1) : B;

    // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
    assign w_den_u = w_b_zero ? 32'd1 : B;
    assign w_den_s = w_b_zero ? 32'd1 : w_b_mag;

    assign w_qu = A / w_den_u;
    assign w_ru = A % w_den_u;

    // Signed divide via magnitudes: 0x80000000 / -1 comes out as 0x80000000 r 0
    // without relying on signed-overflow behaviour of the divider.
    assign w_qm = w_a_mag / w_den_s;
    assign w_rm = w_a_mag % w_den_s;
    assign w_qs = (w_a_neg ^ w_b_neg) ? (~w_qm + 32'd1) : w_qm;
    assign w_rs = w_a_neg ? (~w_rm + 32'd1) : w_rm;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_tmp <= '0;
            r_lo_tmp <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_busy   <= w_busy_nx;
            r_div0   <= w_div0_nx;
            r_hi     <= w_hi_nx;
            r_lo     <= w_lo_nx;
            r_hi_tmp <= w_hi_tmp_nx;
            r_lo_tmp <= w_lo_tmp_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_busy_nx   = r_busy;
        w_div0_nx   = r_div0;
        w_hi_nx     = r_hi;
        w_lo_nx     = r_lo;
        w_hi_tmp_nx = r_hi_tmp;
        w_lo_tmp_nx = r_lo_tmp;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000: begin
                            {w_hi_tmp_nx, w_lo_tmp_nx} = w_prod_s;
                            w_count_nx = CW'(MULT_CYCLES);
                            w_div0_nx  = 1'b0;
                        end
                        3'b001: begin
                            {w_hi_tmp_nx, w_lo_tmp_nx} = w_prod_u;
                            w_count_nx = CW'(MULT_CYCLES);
                            w_div0_nx  = 1'b0;
                        end
                        3'b010: begin
                            w_hi_tmp_nx = w_rs;
                            w_lo_tmp_nx = w_qs;
                            w_count_nx  = CW'(DIV_CYCLES);
                            w_div0_nx   = w_b_zero;
                        end
                        3'b011: begin
                            w_hi_tmp_nx = w_ru;
                            w_lo_tmp_nx = w_qu;
                            w_count_nx  = CW'(DIV_CYCLES);
                            w_div0_nx   = w_b_zero;
                        end
                        3'b100:  w_hi_nx = A;
                        3'b101:  w_lo_nx = A;
                        default: ;
                    endcase
                    if (w_is_long) begin
                        w_busy_nx  = 1'b1;
                        w_state_nx = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_count_nx = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                    if (!r_div0) begin
                        w_hi_nx = r_hi_tmp;
                        w_lo_nx = r_lo_tmp;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign busy     = r_busy;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign stall_md = md_D & (r_busy | (start & w_is_long));

endmodule
